// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, minimum-length padding,
// optional CRC-32 FCS append, underrun signalling and inter-frame gap.
// Build option: define TX_FCS_APPEND_EN to append the 4-byte FCS; without
// it the user supplies the FCS inside the data and frames end after DATA/PAD.
// gmii_txd/gmii_txen/gmii_txer are registered from the current state, so the
// wire lags the state by one cycle; tx_ready/tx_busy are aligned with the state.
module gmii_tx_framer #(
   parameter int unsigned IFG_BYTES = 12,
   parameter int unsigned MIN_FRAME = 60
) (
   input  logic       gmii_tx_clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] gmii_txd,
   output logic       gmii_txen,
   output logic       gmii_txer,
   output logic       tx_busy
);

   localparam int unsigned CNT_W = 11;
   localparam int unsigned TMR_W = 8;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
   localparam logic [TMR_W-1:0] PRE_LAST = TMR_W'(6);
   localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG_BYTES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_SFD   = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_PAD   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd6;
   localparam logic [2:0] S_IFG   = 3'd7;
`ifdef TX_FCS_APPEND_EN
   localparam logic [2:0] S_FCS   = 3'd5;
   localparam logic [2:0] S_END   = S_FCS;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
`else
   localparam logic [2:0] S_END   = S_IFG;
`endif

   logic [2:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [TMR_W-1:0] tmr, tmr_nxt;
   logic [7:0]       txd_nxt;
   logic             txen_nxt, txer_nxt, ready_nxt, busy_nxt;
   logic             accept;
`ifdef TX_FCS_APPEND_EN
   logic [31:0]      crc, crc_nxt, crc_fcs;

   // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   assign crc_fcs = ~crc;
`endif

   assign accept  = tx_valid & tx_ready;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // Next-state, counter, CRC and next-output decode
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmr_nxt   = tmr;
      txd_nxt   = 8'h00;
      txen_nxt  = 1'b0;
      txer_nxt  = 1'b0;
`ifdef TX_FCS_APPEND_EN
      crc_nxt   = crc;
`endif
      case (state)
         S_IDLE: begin
            if (tx_valid) begin
               state_nxt = S_PRE;
               tmr_nxt   = '0;
               cnt_nxt   = '0;
`ifdef TX_FCS_APPEND_EN
               crc_nxt   = CRC_INIT;
`endif
            end
         end
         S_PRE: begin
            txd_nxt  = 8'h55;
            txen_nxt = 1'b1;
            if (tmr == PRE_LAST) state_nxt = S_SFD;
            else                 tmr_nxt   = tmr + TMR_W'(1);
         end
         S_SFD: begin
            txd_nxt   = 8'hD5;
            txen_nxt  = 1'b1;
            state_nxt = S_DATA;
         end
         S_DATA: begin
            txen_nxt = 1'b1;
            if (accept) begin
               txd_nxt = tx_data;
               cnt_nxt = cnt_inc;
`ifdef TX_FCS_APPEND_EN
               crc_nxt = crc32_byte(crc, tx_data);
`endif
               if (tx_last) begin
                  tmr_nxt   = '0;
                  state_nxt = (cnt_inc < MIN_CNT) ? S_PAD : S_END;
               end
            end else begin
               // underrun: one errored cycle, then swallow the rest of the frame
               txer_nxt  = 1'b1;
               state_nxt = S_DRAIN;
            end
         end
         S_PAD: begin
            txen_nxt = 1'b1;
            cnt_nxt  = cnt_inc;
`ifdef TX_FCS_APPEND_EN
            crc_nxt  = crc32_byte(crc, 8'h00);
`endif
            if (cnt_inc >= MIN_CNT) begin
               tmr_nxt   = '0;
               state_nxt = S_END;
            end
         end
`ifdef TX_FCS_APPEND_EN
         S_FCS: begin
            txen_nxt = 1'b1;
            txd_nxt  = 8'(crc_fcs >> {tmr[1:0], 3'b000});
            if (tmr[1:0] == 2'd3) begin
               tmr_nxt   = '0;
               state_nxt = S_IFG;
            end else begin
               tmr_nxt   = tmr + TMR_W'(1);
            end
         end
`endif
         S_DRAIN: begin
            if (accept && tx_last) begin
               tmr_nxt   = '0;
               state_nxt = S_IFG;
            end
         end
         S_IFG: begin
            if (tmr == IFG_LAST) begin
               // a waiting frame starts straight away so the gap stays exact
               if (tx_valid) begin
                  state_nxt = S_PRE;
                  tmr_nxt   = '0;
                  cnt_nxt   = '0;
`ifdef TX_FCS_APPEND_EN
                  crc_nxt   = CRC_INIT;
`endif
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               tmr_nxt = tmr + TMR_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      ready_nxt = (state_nxt == S_DATA) || (state_nxt == S_DRAIN);
      busy_nxt  = (state_nxt != S_IDLE);
   end

   // State, counters and registered outputs
   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         tmr       <= '0;
         gmii_txd  <= 8'h00;
         gmii_txen <= 1'b0;
         gmii_txer <= 1'b0;
         tx_ready  <= 1'b0;
         tx_busy   <= 1'b0;
`ifdef TX_FCS_APPEND_EN
         crc       <= CRC_INIT;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         tmr       <= tmr_nxt;
         gmii_txd  <= txd_nxt;
         gmii_txen <= txen_nxt;
         gmii_txer <= txer_nxt;
         tx_ready  <= ready_nxt;
         tx_busy   <= busy_nxt;
`ifdef TX_FCS_APPEND_EN
         crc       <= crc_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Testbench for gmii_tx_framer: directed frames, scoreboard of expected GMII
// bytes, line-length, gap, underrun and reset checks. Honours TX_FCS_APPEND_EN.
module tb_gmii_tx_framer;

   localparam int IFG = 12;
   localparam int MIN = 60;
`ifdef TX_FCS_APPEND_EN
   localparam int FCS_N = 4;
`else
   localparam int FCS_N = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic [7:0] gmii_txd;
   logic       gmii_txen;
   logic       gmii_txer;
   logic       tx_busy;

   int checks = 0;
   int errors = 0;

   logic [8:0] expq[$];
   logic [7:0] rx_q[$];
   logic [7:0] frm[$];
   int run_hi = 0, run_lo = 0, last_hi = 0, last_gap = 0;

   gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_FRAME(MIN)) dut (
      .gmii_tx_clk(clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .gmii_txd   (gmii_txd),
      .gmii_txen  (gmii_txen),
      .gmii_txer  (gmii_txer),
      .tx_busy    (tx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #4 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int k = 0; k < 32; k++) r[k] = v[31-k];
      return r;
   endfunction

   task automatic push_pre();
      for (int k = 0; k < 7; k++) expq.push_back(9'h055);
      expq.push_back(9'h0D5);
   endtask

   // Expected wire bytes for the whole of frm: preamble, data, pad, FCS
   task automatic push_frame();
      logic [31:0] c;
      int n;
      c = 32'hFFFF_FFFF;
      n = 0;
      push_pre();
      foreach (frm[i]) begin
         expq.push_back({1'b0, frm[i]});
         c = crc_upd(c, frm[i]);
         n++;
      end
      while (n < MIN) begin
         expq.push_back(9'h000);
         c = crc_upd(c, 8'h00);
         n++;
      end
      c = ~c;
      for (int k = 0; k < FCS_N; k++) expq.push_back({1'b0, c[k*8 +: 8]});
   endtask

   // Present frm byte by byte; call and return at a falling edge
   task automatic send(input bit keep, input int drop_at);
      for (int i = 0; i < frm.size(); i++) begin
         int   guard;
         logic acc;
         if (i == drop_at) begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
            @(negedge clk);
         end
         tx_valid = 1'b1;
         tx_data  = frm[i];
         tx_last  = (i == frm.size() - 1);
         guard    = 0;
         forever begin
            acc = tx_ready;
            @(negedge clk);
            if (acc) break;
            guard++;
            if (guard > 4000) begin
               check("send_timeout", 32'(tx_ready), 32'd1);
               tx_valid = 1'b0;
               return;
            end
         end
      end
      if (!keep) begin
         tx_valid = 1'b0;
         tx_last  = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((tx_busy || gmii_txen) && g < 5000) begin
         @(negedge clk);
         g++;
      end
      check("idle_reached", 32'(tx_busy), 32'd0);
   endtask

   task automatic check_residue(input string tag);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      for (int i = 8; i < rx_q.size(); i++) r = crc_upd(r, rx_q[i]);
      check(tag, bitrev32(r), 32'hC704_DD7B);
   endtask

   // Wire monitor: scoreboard pop on every txen cycle, idle-line checks otherwise
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_hi = 0;
            run_lo = 0;
         end else if (gmii_txen) begin
            if (run_hi == 0) last_gap = run_lo;
            run_lo = 0;
            run_hi++;
            rx_q.push_back(gmii_txd);
            if (expq.size() == 0) begin
               check("txen_unexpected", 32'(gmii_txen), 32'd0);
            end else begin
               e = expq.pop_front();
               check("txd", 32'(gmii_txd), 32'(e[7:0]));
               check("txer", 32'(gmii_txer), 32'(e[8]));
            end
         end else begin
            if (run_hi > 0) last_hi = run_hi;
            run_hi = 0;
            run_lo++;
            check("txer_idle", 32'(gmii_txer), 32'd0);
            check("txd_idle", 32'(gmii_txd), 32'd0);
         end
      end
   end

   initial begin
      int n;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(gmii_txd), 32'd0);
      check("rst_txen", 32'(gmii_txen), 32'd0);
      check("rst_txer", 32'(gmii_txer), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd0);
      check("rst_busy", 32'(tx_busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ready", 32'(tx_ready), 32'd0);

      // 64-byte incrementing frame
      frm.delete();
      for (int i = 0; i < 64; i++) frm.push_back(8'(i));
      rx_q.delete();
      push_frame();
      send(1'b0, -1);
      wait_idle();
      check("len_64", 32'(last_hi), 32'(8 + 64 + FCS_N));
`ifdef TX_FCS_APPEND_EN
      check_residue("residue_64");
`endif

      // 1-byte frame padded to minimum
      frm.delete();
      frm.push_back(8'hAB);
      rx_q.delete();
      push_frame();
      send(1'b0, -1);
      wait_idle();
      check("len_1", 32'(last_hi), 32'(8 + MIN + FCS_N));
`ifdef TX_FCS_APPEND_EN
      check_residue("residue_1");
`endif

      // Two back-to-back 60-byte frames with tx_valid held high
      frm.delete();
      for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
      push_frame();
      send(1'b1, -1);
      frm.delete();
      for (int i = 0; i < 60; i++) frm.push_back(8'($urandom));
      push_frame();
      send(1'b0, -1);
      wait_idle();
      check("b2b_gap", 32'(last_gap), 32'(IFG));
      check("len_60", 32'(last_hi), 32'(8 + 60 + FCS_N));

      // Underrun after byte 10 of 40
      frm.delete();
      for (int i = 1; i <= 40; i++) frm.push_back(8'(i));
      push_pre();
      for (int i = 0; i < 10; i++) expq.push_back({1'b0, frm[i]});
      expq.push_back(9'h100);
      send(1'b0, 10);
      n = 0;
      while (tx_busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("drain_ifg", 32'(n), 32'(IFG));
      check("underrun_len", 32'(last_hi), 32'd19);
      check("underrun_busy", 32'(tx_busy), 32'd0);

      // Reset in the middle of the frame tail (FCS when appended)
      frm.delete();
      for (int i = 0; i < 60; i++) frm.push_back(8'(i * 3));
      push_frame();
      send(1'b0, -1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_txd", 32'(gmii_txd), 32'd0);
      check("mid_rst_txen", 32'(gmii_txen), 32'd0);
      check("mid_rst_txer", 32'(gmii_txer), 32'd0);
      check("mid_rst_ready", 32'(tx_ready), 32'd0);
      check("mid_rst_busy", 32'(tx_busy), 32'd0);
      expq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Clean frame after reset release
      frm.delete();
      for (int i = 0; i < 60; i++) frm.push_back(8'(255 - i));
      rx_q.delete();
      push_frame();
      send(1'b0, -1);
      wait_idle();
      check("post_rst_len", 32'(last_hi), 32'(8 + 60 + FCS_N));
`ifdef TX_FCS_APPEND_EN
      check_residue("residue_post_rst");
`endif
      repeat (4) @(negedge clk);
      check("queue_empty", 32'(expq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Parameter IFG_BYTES, default 12, idle cycles (gmii_txen low) enforced after each frame before the next preamble.
REQ-002 Parameter MIN_FRAME, default 60, minimum bytes (data plus pad) sent before FCS.
REQ-003 gmii_tx_clk  in  1  sole clock, 125 MHz; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 tx_data  in  8  user frame byte, destination MAC first.
REQ-006 tx_valid  in  1  tx_data valid.
REQ-007 tx_last  in  1  qualifies the final byte of a frame.
REQ-008 tx_ready  out  1  byte accepted when tx_valid and tx_ready are both high.
REQ-009 gmii_txd  out  8  GMII transmit byte.
REQ-010 gmii_txen  out  1  GMII transmit enable.
REQ-011 gmii_txer  out  1  GMII transmit error.
REQ-012 tx_busy  out  1  high in every state except IDLE.

Function
REQ-013 All outputs shall be registered; FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG.
REQ-014 IDLE: tx_valid=1 shall move to PRE next cycle; no byte is accepted in IDLE.
REQ-015 PRE: 7 cycles gmii_txen=1, gmii_txd=0x55; SFD: 1 cycle gmii_txd=0xD5.
REQ-016 tx_ready shall be high only in DATA and DRAIN; first data byte appears on gmii_txd on the 9th cycle after leaving IDLE.
REQ-017 DATA: each accepted byte shall be driven on gmii_txd the following cycle with gmii_txen=1; byte counter (11 bits, saturating at 2047) increments per byte.
REQ-018 Accepted tx_last with count below MIN_FRAME shall go to PAD, sending 0x00 until count reaches MIN_FRAME; otherwise go to FCS.
REQ-019 FCS: 4 cycles of CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final complement) over data and pad, least-significant byte first.
REQ-020 Underrun: tx_valid=0 in DATA shall drive one cycle gmii_txen=1, gmii_txer=1, gmii_txd=0x00, then enter DRAIN.
REQ-021 DRAIN: gmii_txen=0; accepted bytes shall be discarded until tx_last is accepted, then enter IFG.
REQ-022 IFG: gmii_txen=0, gmii_txd=0x00 for exactly IFG_BYTES cycles, then IDLE; tx_valid held high shall start the next frame with no extra gap.
REQ-023 gmii_txer shall be 0 in all cases other than REQ-020.
REQ-024 tx_last with tx_valid=1 on the first DATA byte shall be a legal 1-byte frame.

Reset
REQ-025 rst_n low shall immediately force IDLE, gmii_txd=0x00, gmii_txen=0, gmii_txer=0, tx_ready=0, tx_busy=0, counter=0, CRC=0xFFFFFFFF.
REQ-026 Reset mid-frame shall truncate the frame with no FCS; after release the first frame shall start from IDLE.

Configuration
REQ-027 Macro TX_FCS_APPEND_EN defined: FCS state inserted per REQ-019.
REQ-028 TX_FCS_APPEND_EN undefined: FCS state and CRC logic removed; DATA or PAD go directly to IFG; user supplies the FCS inside the data.

Verification
REQ-029 64-byte frame 0x00..0x3F, macro on -> 8 preamble/SFD, 64 data bytes, 4 FCS bytes; 76 gmii_txen cycles; CRC over data plus FCS yields residue 0xC704DD7B.
REQ-030 1-byte frame 0xAB -> 0xAB, then 59 bytes of 0x00, then FCS; gmii_txen high 72 cycles.
REQ-031 Two back-to-back 60-byte frames with tx_valid held high -> exactly 12 low gmii_txen cycles between frames.
REQ-032 tx_valid dropped after byte 10 of 40 -> one cycle txen=1/txer=1, then bytes 11..40 absorbed with txen=0, then 12 IFG cycles, tx_busy=0.
REQ-033 rst_n asserted during FCS byte 2 -> outputs 0 asynchronously; a 60-byte frame after release is correct.
REQ-034 Macro off, 64-byte frame -> 72 gmii_txen cycles, no bytes appended.
